scpad_bank_arb: RTL and testbench
=================================

// Module: scpad_bank_arb
// PURPOSE
//  Per-bank scratchpad SRAM front end. Buffers write and read requests in separate parametrised FIFOs.
//  Arbitrates a single SRAM port with read priority and a bounded write-starvation guarantee.
//  Returns read data with its tag after a fixed SRAM latency.
//  One instance per scratchpad bank, between the crossbar and the SRAM macro.
// PARAMETERS
//  DWIDTH      512  data width (bits)
//  AWIDTH      10   bank row address width
//  TAG_W       6    read tag width, echoed on response
//  WR_DEPTH    4    write FIFO depth (power of 2, >=2)
//  RD_DEPTH    4    read FIFO depth (power of 2, >=2)
//  SRAM_LAT    2    cycles from SRAM read issue to sram_rdata valid (>=1)
//  STARVE_MAX  8    max consecutive cycles a pending write may lose arbitration
// PORTS
//  clk         in   1            clock
//  n_rst       in   1            async active-low reset
//  wr_valid    in   1            write request valid
//  wr_ready    out  1            write FIFO not full
//  wr_addr     in   AWIDTH       write row address
//  wr_data     in   DWIDTH       write data
//  rd_valid    in   1            read request valid
//  rd_ready    out  1            read FIFO not full
//  rd_addr     in   AWIDTH       read row address
//  rd_tag      in   TAG_W        read tag
//  sram_busy   in   1            SRAM cannot accept a request this cycle
//  sram_en     out  1            SRAM request strobe
//  sram_we     out  1            1=write, 0=read (valid with sram_en)
//  sram_addr   out  AWIDTH       SRAM address
//  sram_wdata  out  DWIDTH       SRAM write data
//  sram_rdata  in   DWIDTH       SRAM read data
//  rsp_valid   out  1            read response valid (no backpressure)
//  rsp_data    out  DWIDTH       read response data
//  rsp_tag     out  TAG_W        read response tag
// BEHAVIOUR
//  - Reset: FIFOs empty, state ARB_RD, starve count 0, latency pipe cleared. All outputs 0 except wr_ready=rd_ready=1.
//  - Accept: a push occurs on valid&&ready; ready = !full. A full FIFO never accepts, even with a same-cycle pop.
//  - Requests are visible to the arbiter the cycle after the push. Min accept-to-sram_en latency = 1 cycle.
//  - Issue: sram_en=1 only when !sram_busy and the selected FIFO is non-empty. The head is popped in that same cycle.
//  - sram_en/sram_we/sram_addr/sram_wdata are combinational from the FIFO heads and the arbiter decision. They are 0 when no issue.
//  - FSM ARB_RD: read is issued if the read FIFO is non-empty, else write.
//  - FSM ARB_WR: write is issued if the write FIFO is non-empty, else read.
//  - FSM transitions:
//    - ARB_RD -> ARB_WR when starve==STARVE_MAX or the write FIFO is full.
//    - ARB_WR -> ARB_RD after one write is issued, unless the write FIFO is still full.
//    - ARB_WR -> ARB_RD when the write FIFO is empty.
//  - Starve count: increments when the write FIFO is non-empty and no write is issued, including sram_busy cycles. Clears on write issue or when the write FIFO is empty. Saturates at STARVE_MAX.
//  - Response: a read issued in cycle i gives rsp_valid=1 in cycle i+SRAM_LAT.
//    - rsp_data = sram_rdata in that cycle; rsp_tag = the tag issued in cycle i.
//    - The tag/valid shift pipe is SRAM_LAT deep. Back-to-back reads produce back-to-back responses.
//  - Ordering: reads complete in issue order. No address hazard check between the FIFOs; the crossbar owns RAW ordering.
//  - Mid-operation reset: in-flight reads are discarded (rsp_valid forced 0) and FIFO contents are dropped.
// CONFIGURATION
//  - SCPAD_BANK_PERF_EN defined: adds output ports
//    - perf_rd_cnt [31:0]: reads issued.
//    - perf_wr_cnt [31:0]: writes issued.
//    - perf_busy_cnt [31:0]: cycles with sram_busy=1 and a non-empty FIFO.
//    - Counters wrap, reset to 0, increment same cycle as event.
//  - SCPAD_BANK_PERF_EN undefined: ports and counters are absent; functional behaviour is identical.
// STRUCTURE
//  - scpad_pkg adds:
//    - scpad_wr_req_t {addr,data} and scpad_rd_req_t {addr,tag}.
//    - arb_state_t enum {ARB_RD, ARB_WR}.
//  - FIFOs: two sync_fifo instances.
//  - Sub-module scpad_lat_pipe (param DEPTH=SRAM_LAT, W=TAG_W+1): valid/tag delay line with async clear.
// TESTING
//  - Single read: rd addr 0x012 tag 5, SRAM_LAT=2, sram_busy=0 -> sram_en/!sram_we cycle t+1; rsp_valid, tag 5 at t+3.
//  - Read priority: rd and wr both pending -> read issued first, write next idle cycle.
//  - Starvation: write queued, continuous reads, STARVE_MAX=8 -> write issued on the 9th arbitration cycle.
//  - Starvation, continued: reads resume afterwards.
//  - Full FIFOs: hold sram_busy=1, push 4 writes -> wr_ready=0. 5th push is ignored; releasing busy drains 4 writes, in order.
//  - Busy stall: sram_busy high 3 cycles with pending read -> sram_en=0 throughout; issue on the first non-busy cycle, starve count frozen only if no write is pending.
//  - Reset mid-read: assert n_rst low 1 cycle after a read issue -> rsp_valid never asserts, FIFOs empty, ready=1 after reset.

Source files
------------

// File: rtl/scpad_pkg.sv
// Shared types and default widths for the scratchpad bank front end.
// Optional perf counters are enabled with SCPAD_BANK_PERF_EN.
package scpad_pkg;

    localparam int unsigned SCPAD_DWIDTH = 512;
    localparam int unsigned SCPAD_AWIDTH = 10;
    localparam int unsigned SCPAD_TAG_W  = 6;

    typedef enum logic {
        ARB_RD = 1'b0,
        ARB_WR = 1'b1
    } arb_state_t;

    typedef struct packed {
        logic [SCPAD_AWIDTH-1:0] addr;
        logic [SCPAD_DWIDTH-1:0] data;
    } scpad_wr_req_t;

    typedef struct packed {
        logic [SCPAD_AWIDTH-1:0] addr;
        logic [SCPAD_TAG_W-1:0]  tag;
    } scpad_rd_req_t;

endpackage

// File: rtl/scpad_lat_pipe.sv
// Fixed-depth delay line carrying {valid, tag} alongside the SRAM read latency.
// Asynchronous clear discards everything in flight.
module scpad_lat_pipe #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned W     = 7
) (
    input  logic         clk,
    input  logic         n_rst,
    input  logic [W-1:0] data_i,
    output logic [W-1:0] data_o
);

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_stage
            logic [W-1:0] stage_d;
            logic [W-1:0] stage_q;

            if (gi == 0) begin : g_head
                assign stage_d = data_i;
            end else begin : g_tail
                assign stage_d = g_stage[gi-1].stage_q;
            end

            always_ff @(posedge clk or negedge n_rst) begin
                if (!n_rst) begin
                    stage_q <= '0;
                end else begin
                    stage_q <= stage_d;
                end
            end
        end
    endgenerate

    assign data_o = g_stage[DEPTH-1].stage_q;

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a combinational head; a full FIFO rejects pushes
// even when a pop happens in the same cycle.
module sync_fifo #(
    parameter int unsigned W     = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic         clk,
    input  logic         n_rst,
    input  logic         push_i,
    input  logic [W-1:0] data_i,
    input  logic         pop_i,
    output logic [W-1:0] data_o,
    output logic         full_o,
    output logic         empty_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [W-1:0] mem_q [DEPTH];
    logic [AW:0]  wr_ptr_q, wr_ptr_d;
    logic [AW:0]  rd_ptr_q, rd_ptr_d;
    logic         push_en, pop_en;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    assign push_en  = push_i && !full_o;
    assign pop_en   = pop_i && !empty_o;
    assign wr_ptr_d = wr_ptr_q + (AW+1)'(push_en);
    assign rd_ptr_d = rd_ptr_q + (AW+1)'(pop_en);
    assign data_o   = mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_en) begin
            mem_q[wr_ptr_q[AW-1:0]] <= data_i;
        end
    end

endmodule

// File: rtl/scpad_bank_arb.sv
// Per-bank scratchpad SRAM front end: write/read FIFOs, read-priority arbiter
// with bounded write starvation, tagged read return. SCPAD_BANK_PERF_EN adds perf counters.
module scpad_bank_arb
    import scpad_pkg::*;
#(
    parameter int unsigned DWIDTH     = SCPAD_DWIDTH,
    parameter int unsigned AWIDTH     = SCPAD_AWIDTH,
    parameter int unsigned TAG_W      = SCPAD_TAG_W,
    parameter int unsigned WR_DEPTH   = 4,
    parameter int unsigned RD_DEPTH   = 4,
    parameter int unsigned SRAM_LAT   = 2,
    parameter int unsigned STARVE_MAX = 8
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [AWIDTH-1:0] wr_addr,
    input  logic [DWIDTH-1:0] wr_data,
    input  logic              rd_valid,
    output logic              rd_ready,
    input  logic [AWIDTH-1:0] rd_addr,
    input  logic [TAG_W-1:0]  rd_tag,
    input  logic              sram_busy,
    output logic              sram_en,
    output logic              sram_we,
    output logic [AWIDTH-1:0] sram_addr,
    output logic [DWIDTH-1:0] sram_wdata,
    input  logic [DWIDTH-1:0] sram_rdata,
    output logic              rsp_valid,
    output logic [DWIDTH-1:0] rsp_data,
    output logic [TAG_W-1:0]  rsp_tag
`ifdef SCPAD_BANK_PERF_EN
    ,
    output logic [31:0]       perf_rd_cnt,
    output logic [31:0]       perf_wr_cnt,
    output logic [31:0]       perf_busy_cnt
`endif
);

    localparam int unsigned SW = $clog2(STARVE_MAX + 1);

    typedef struct packed {
        logic [AWIDTH-1:0] addr;
        logic [DWIDTH-1:0] data;
    } wr_req_t;

    typedef struct packed {
        logic [AWIDTH-1:0] addr;
        logic [TAG_W-1:0]  tag;
    } rd_req_t;

    wr_req_t    wr_push_req, wr_head;
    rd_req_t    rd_push_req, rd_head;
    logic       wr_full, wr_empty, rd_full, rd_empty;
    logic       sel_wr, issue, wr_issue, rd_issue;
    arb_state_t state_q, state_d;
    logic [SW-1:0]  starve_q, starve_d;
    logic [TAG_W:0] pipe_in, pipe_out;

    assign wr_push_req = '{addr: wr_addr, data: wr_data};
    assign rd_push_req = '{addr: rd_addr, tag: rd_tag};
    assign wr_ready    = !wr_full;
    assign rd_ready    = !rd_full;

    sync_fifo #(
        .W     ($bits(wr_req_t)),
        .DEPTH (WR_DEPTH)
    ) u_wr_fifo (
        .clk     (clk),
        .n_rst   (n_rst),
        .push_i  (wr_valid),
        .data_i  (wr_push_req),
        .pop_i   (wr_issue),
        .data_o  (wr_head),
        .full_o  (wr_full),
        .empty_o (wr_empty)
    );

    sync_fifo #(
        .W     ($bits(rd_req_t)),
        .DEPTH (RD_DEPTH)
    ) u_rd_fifo (
        .clk     (clk),
        .n_rst   (n_rst),
        .push_i  (rd_valid),
        .data_i  (rd_push_req),
        .pop_i   (rd_issue),
        .data_o  (rd_head),
        .full_o  (rd_full),
        .empty_o (rd_empty)
    );

    // Each state prefers its own FIFO and falls back to the other when empty.
    always_comb begin
        sel_wr = 1'b0;
        case (state_q)
            ARB_RD:  sel_wr = rd_empty && !wr_empty;
            ARB_WR:  sel_wr = !wr_empty;
            default: sel_wr = 1'b0;
        endcase
        issue    = !sram_busy && !(rd_empty && wr_empty);
        wr_issue = issue && sel_wr;
        rd_issue = issue && !sel_wr;
    end

    assign sram_en    = issue;
    assign sram_we    = wr_issue;
    assign sram_addr  = wr_issue ? wr_head.addr : (rd_issue ? rd_head.addr : '0);
    assign sram_wdata = wr_issue ? wr_head.data : '0;

    // Switching on the updated count lets the write win on the arbitration
    // cycle right after it has lost STARVE_MAX times in a row.
    always_comb begin
        starve_d = starve_q;
        if (wr_empty || wr_issue) begin
            starve_d = '0;
        end else if (starve_q != SW'(STARVE_MAX)) begin
            starve_d = starve_q + 1'b1;
        end

        state_d = state_q;
        case (state_q)
            ARB_RD: begin
                if ((starve_d == SW'(STARVE_MAX)) || wr_full) begin
                    state_d = ARB_WR;
                end
            end
            ARB_WR: begin
                // A popped FIFO cannot be full next cycle since full rejects pushes.
                if (wr_empty || wr_issue) begin
                    state_d = ARB_RD;
                end
            end
            default: state_d = ARB_RD;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q  <= ARB_RD;
            starve_q <= '0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
        end
    end

    assign pipe_in = {rd_issue, (rd_issue ? rd_head.tag : {TAG_W{1'b0}})};

    scpad_lat_pipe #(
        .DEPTH (SRAM_LAT),
        .W     (TAG_W + 1)
    ) u_lat_pipe (
        .clk    (clk),
        .n_rst  (n_rst),
        .data_i (pipe_in),
        .data_o (pipe_out)
    );

    assign rsp_valid = pipe_out[TAG_W];
    assign rsp_tag   = pipe_out[TAG_W-1:0];
    assign rsp_data  = rsp_valid ? sram_rdata : '0;

`ifdef SCPAD_BANK_PERF_EN
    logic [31:0] perf_rd_q, perf_wr_q, perf_busy_q;
    logic        busy_evt;

    assign busy_evt = sram_busy && !(rd_empty && wr_empty);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            perf_rd_q   <= '0;
            perf_wr_q   <= '0;
            perf_busy_q <= '0;
        end else begin
            perf_rd_q   <= perf_rd_q + 32'(rd_issue);
            perf_wr_q   <= perf_wr_q + 32'(wr_issue);
            perf_busy_q <= perf_busy_q + 32'(busy_evt);
        end
    end

    assign perf_rd_cnt   = perf_rd_q;
    assign perf_wr_cnt   = perf_wr_q;
    assign perf_busy_cnt = perf_busy_q;
`endif

endmodule

// File: tb/tb_scpad_bank_arb.sv
// Scoreboard bench for scpad_bank_arb: expected SRAM issues and read responses are
// queued as stimulus is driven and checked as the DUT produces them.
module tb_scpad_bank_arb;
    import scpad_pkg::*;

    localparam int DW  = 512;
    localparam int AW  = 10;
    localparam int TW  = 6;
    localparam int LAT = 2;

    logic          clk = 1'b0;
    logic          n_rst = 1'b0;
    logic          wr_valid = 1'b0, rd_valid = 1'b0, sram_busy = 1'b0;
    logic [AW-1:0] wr_addr = '0, rd_addr = '0;
    logic [DW-1:0] wr_data = '0;
    logic [TW-1:0] rd_tag = '0;
    logic          wr_ready, rd_ready, sram_en, sram_we, rsp_valid;
    logic [AW-1:0] sram_addr;
    logic [DW-1:0] sram_wdata, sram_rdata, rsp_data;
    logic [TW-1:0] rsp_tag;
`ifdef SCPAD_BANK_PERF_EN
    logic [31:0]   perf_rd_cnt, perf_wr_cnt, perf_busy_cnt;
`endif

    scpad_bank_arb #(
        .DWIDTH(DW), .AWIDTH(AW), .TAG_W(TW), .WR_DEPTH(4), .RD_DEPTH(4),
        .SRAM_LAT(LAT), .STARVE_MAX(8)
    ) dut (
        .clk(clk), .n_rst(n_rst),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr), .rd_tag(rd_tag),
        .sram_busy(sram_busy), .sram_en(sram_en), .sram_we(sram_we), .sram_addr(sram_addr),
        .sram_wdata(sram_wdata), .sram_rdata(sram_rdata),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_tag(rsp_tag)
`ifdef SCPAD_BANK_PERF_EN
        , .perf_rd_cnt(perf_rd_cnt), .perf_wr_cnt(perf_wr_cnt), .perf_busy_cnt(perf_busy_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } iss_t;

    typedef struct {
        logic [TW-1:0] tag;
        logic [DW-1:0] data;
        int            at;
    } rsp_t;

    iss_t exp_iss[$];
    rsp_t exp_rsp[$];
    int   checks = 0, errors = 0;
    int   cyc = 0, last_wr_cyc = -1, n_rd = 0, n_wr = 0;

    function automatic logic [DW-1:0] pat(input logic [AW-1:0] a);
        return {16{6'h2A, a, 16'hBEEF}};
    endfunction

    function automatic logic [DW-1:0] wdat(input int k);
        logic [31:0] w;
        w = 32'h5A5A_0000 ^ k;
        return {16{w}};
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // SRAM model: data for a read issued in cycle i is driven in cycle i+LAT.
    logic          rcap_v = 1'b0;
    logic [AW-1:0] rcap_a = '0;
    logic          rp_v [LAT] = '{default: 1'b0};
    logic [AW-1:0] rp_a [LAT] = '{default: '0};

    always @(posedge clk) begin
        rp_v[0] <= rcap_v;
        rp_a[0] <= rcap_a;
        for (int i = 1; i < LAT; i++) begin
            rp_v[i] <= rp_v[i-1];
            rp_a[i] <= rp_a[i-1];
        end
    end

    assign sram_rdata = rp_v[LAT-1] ? pat(rp_a[LAT-1]) : {16{32'hDEAD_BEEF}};

    // Monitor: pops the scoreboard on every SRAM issue and every response.
    always @(negedge clk) begin
        iss_t ie;
        rsp_t re;
        rcap_v = 1'b0;
        checks++;
        if (sram_en === 1'b1) begin
            $display("issue  cyc=%0d we=%0b addr=%h", cyc, sram_we, sram_addr);
            if (exp_iss.size() == 0) begin
                errors++;
                $display("FAIL issue_unexpected cyc=%0d got we=%0b addr=%h, none expected", cyc, sram_we, sram_addr);
            end else begin
                ie = exp_iss.pop_front();
                if (sram_we !== ie.we || sram_addr !== ie.addr || sram_wdata !== ie.data) begin
                    errors++;
                    $display("FAIL issue cyc=%0d got we=%0b addr=%h wd=%h, expected we=%0b addr=%h wd=%h",
                             cyc, sram_we, sram_addr, sram_wdata[31:0], ie.we, ie.addr, ie.data[31:0]);
                end
            end
            if (sram_we === 1'b0) begin
                rcap_v = 1'b1;
                rcap_a = sram_addr;
                n_rd++;
            end else begin
                last_wr_cyc = cyc;
                n_wr++;
            end
        end else if (sram_en !== 1'b0 || sram_we !== 1'b0 || sram_addr !== '0 || sram_wdata !== '0) begin
            errors++;
            $display("FAIL idle_outputs cyc=%0d got en=%b we=%b addr=%h, expected all 0", cyc, sram_en, sram_we, sram_addr);
        end
        if (rsp_valid !== 1'b0) begin
            checks++;
            $display("rsp    cyc=%0d tag=%0d", cyc, rsp_tag);
            if (exp_rsp.size() == 0) begin
                errors++;
                $display("FAIL rsp_unexpected cyc=%0d got valid=%b tag=%0d, none expected", cyc, rsp_valid, rsp_tag);
            end else begin
                re = exp_rsp.pop_front();
                if (rsp_valid !== 1'b1 || rsp_tag !== re.tag || rsp_data !== re.data || (re.at >= 0 && re.at != cyc)) begin
                    errors++;
                    $display("FAIL rsp cyc=%0d got tag=%0d data=%h, expected tag=%0d data=%h at cyc=%0d",
                             cyc, rsp_tag, rsp_data[31:0], re.tag, re.data[31:0], re.at);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic exp_rd(input logic [AW-1:0] a, input logic [TW-1:0] tg, input int at, input bit with_rsp);
        iss_t i;
        rsp_t r;
        i.we = 1'b0; i.addr = a; i.data = '0;
        exp_iss.push_back(i);
        if (with_rsp) begin
            r.tag = tg; r.data = pat(a); r.at = at;
            exp_rsp.push_back(r);
        end
    endtask

    task automatic exp_wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
        iss_t i;
        i.we = 1'b1; i.addr = a; i.data = d;
        exp_iss.push_back(i);
    endtask

    task automatic drain(input int budget);
        for (int i = 0; i < budget && (exp_iss.size() + exp_rsp.size()) != 0; i++) step();
        step();
    endtask

    task automatic test_reset();
        step(); step();
        checks++;
        if ({wr_ready, rd_ready} !== 2'b11) begin
            errors++;
            $display("FAIL reset_ready got %b, expected 11", {wr_ready, rd_ready});
        end
        checks++;
        if (sram_en !== 0 || sram_we !== 0 || sram_addr !== 0 || sram_wdata !== 0 ||
            rsp_valid !== 0 || rsp_data !== 0 || rsp_tag !== 0) begin
            errors++;
            $display("FAIL reset_outputs got en=%b we=%b rv=%b tag=%0d, expected all 0", sram_en, sram_we, rsp_valid, rsp_tag);
        end
        n_rst = 1'b1;
        step();
    endtask

    task automatic test_single_read();
        int t = cyc;
        exp_rd(10'h012, 6'd5, t + 3, 1'b1);
        rd_valid = 1'b1; rd_addr = 10'h012; rd_tag = 6'd5;
        step();
        rd_valid = 1'b0;
        checks++;
        if (sram_en !== 1'b1 || sram_we !== 1'b0) begin
            errors++;
            $display("FAIL single_issue got en=%b we=%b at t+1, expected en=1 we=0", sram_en, sram_we);
        end
        drain(20);
        checks++;
        if (exp_iss.size() + exp_rsp.size() != 0) begin
            errors++;
            $display("FAIL single_drain got %0d pending, expected 0", exp_iss.size() + exp_rsp.size());
        end
    endtask

    task automatic test_reset_mid_read();
        exp_rd(10'h0AA, 6'd44, -1, 1'b0);
        rd_valid = 1'b1; rd_addr = 10'h0AA; rd_tag = 6'd44;
        step();
        rd_addr = 10'h0BB; rd_tag = 6'd45;
        wr_valid = 1'b1; wr_addr = 10'h0CC; wr_data = wdat(7);
        step();
        rd_valid = 1'b0; wr_valid = 1'b0;
        n_rst = 1'b0;
        #1;
        checks++;
        if (rsp_valid !== 1'b0 || sram_en !== 1'b0 || {wr_ready, rd_ready} !== 2'b11) begin
            errors++;
            $display("FAIL midrst_state got rv=%b en=%b ready=%b, expected 0 0 11", rsp_valid, sram_en, {wr_ready, rd_ready});
        end
        n_rd = 0; n_wr = 0;
        step();
        n_rst = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            checks++;
            if (rsp_valid !== 1'b0 || {wr_ready, rd_ready} !== 2'b11) begin
                errors++;
                $display("FAIL midrst_after got rv=%b ready=%b, expected 0 11", rsp_valid, {wr_ready, rd_ready});
            end
        end
        checks++;
        if (exp_iss.size() != 0) begin
            errors++;
            $display("FAIL midrst_issue got %0d unissued, expected 0", exp_iss.size());
        end
    endtask

    task automatic test_read_priority();
        int t = cyc;
        exp_rd(10'h030, 6'd9, t + 3, 1'b1);
        exp_wr(10'h020, wdat(1));
        wr_valid = 1'b1; wr_addr = 10'h020; wr_data = wdat(1);
        rd_valid = 1'b1; rd_addr = 10'h030; rd_tag = 6'd9;
        step();
        wr_valid = 1'b0; rd_valid = 1'b0;
        checks++;
        if (sram_en !== 1'b1 || sram_we !== 1'b0) begin
            errors++;
            $display("FAIL prio_first got en=%b we=%b, expected read (1 0)", sram_en, sram_we);
        end
        step();
        checks++;
        if (sram_en !== 1'b1 || sram_we !== 1'b1 || sram_addr !== 10'h020) begin
            errors++;
            $display("FAIL prio_second got en=%b we=%b addr=%h, expected write to 020", sram_en, sram_we, sram_addr);
        end
        drain(20);
        checks++;
        if (exp_iss.size() + exp_rsp.size() != 0) begin
            errors++;
            $display("FAIL prio_drain got %0d pending, expected 0", exp_iss.size() + exp_rsp.size());
        end
    endtask

    task automatic test_back_to_back();
        int t = cyc;
        for (int k = 0; k < 4; k++) exp_rd(AW'(10'h080 + k), TW'(20 + k), t + k + 3, 1'b1);
        for (int k = 0; k < 4; k++) begin
            rd_valid = 1'b1; rd_addr = AW'(10'h080 + k); rd_tag = TW'(20 + k);
            step();
        end
        rd_valid = 1'b0;
        drain(20);
        checks++;
        if (exp_iss.size() + exp_rsp.size() != 0) begin
            errors++;
            $display("FAIL b2b_drain got %0d pending, expected 0", exp_iss.size() + exp_rsp.size());
        end
    endtask

    task automatic test_starvation();
        int t = cyc;
        for (int k = 0; k < 12; k++) begin
            if (k == 8) exp_wr(10'h100, wdat(2));
            exp_rd(AW'(10'h200 + k), TW'(k), (k < 8) ? t + k + 3 : t + k + 4, 1'b1);
        end
        for (int k = 0; k < 12; k++) begin
            wr_valid = (k == 0); wr_addr = 10'h100; wr_data = wdat(2);
            rd_valid = 1'b1; rd_addr = AW'(10'h200 + k); rd_tag = TW'(k);
            checks++;
            if (rd_ready !== 1'b1) begin
                errors++;
                $display("FAIL starve_rd_ready k=%0d got %b, expected 1", k, rd_ready);
            end
            step();
        end
        wr_valid = 1'b0; rd_valid = 1'b0;
        drain(30);
        checks++;
        if (last_wr_cyc != t + 9) begin
            errors++;
            $display("FAIL starve_wr_cycle got cyc=%0d, expected %0d", last_wr_cyc, t + 9);
        end
        checks++;
        if (exp_iss.size() + exp_rsp.size() != 0) begin
            errors++;
            $display("FAIL starve_drain got %0d pending, expected 0", exp_iss.size() + exp_rsp.size());
        end
    endtask

    task automatic test_busy_stall();
        int t = cyc;
        exp_rd(10'h060, 6'd33, t + 6, 1'b1);
        exp_wr(10'h070, wdat(3));
        sram_busy = 1'b1;
        rd_valid = 1'b1; rd_addr = 10'h060; rd_tag = 6'd33;
        wr_valid = 1'b1; wr_addr = 10'h070; wr_data = wdat(3);
        step();
        rd_valid = 1'b0; wr_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (sram_en !== 1'b0) begin
                errors++;
                $display("FAIL busy_hold cyc=%0d got en=%b, expected 0", cyc, sram_en);
            end
            step();
        end
        sram_busy = 1'b0;
        #1;
        checks++;
        if (sram_en !== 1'b1 || sram_we !== 1'b0) begin
            errors++;
            $display("FAIL busy_release got en=%b we=%b, expected read (1 0)", sram_en, sram_we);
        end
        drain(20);
        checks++;
        if (last_wr_cyc != t + 5 || exp_iss.size() + exp_rsp.size() != 0) begin
            errors++;
            $display("FAIL busy_write got cyc=%0d pending=%0d, expected cyc=%0d pending=0",
                     last_wr_cyc, exp_iss.size() + exp_rsp.size(), t + 5);
        end
    endtask

    task automatic test_full();
        int t = cyc;
        exp_wr(10'h040, wdat(16));
        for (int k = 0; k < 4; k++) exp_rd(AW'(10'h050 + k), TW'(16 + k), t + 9 + k, 1'b1);
        for (int k = 1; k < 4; k++) exp_wr(AW'(10'h040 + k), wdat(16 + k));
        sram_busy = 1'b1;
        for (int k = 0; k < 4; k++) begin
            wr_valid = 1'b1; wr_addr = AW'(10'h040 + k); wr_data = wdat(16 + k);
            rd_valid = 1'b1; rd_addr = AW'(10'h050 + k); rd_tag = TW'(16 + k);
            step();
        end
        wr_addr = 10'h3FF; wr_data = wdat(99);
        rd_addr = 10'h3FE; rd_tag = 6'd63;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if ({wr_ready, rd_ready} !== 2'b00 || sram_en !== 1'b0) begin
                errors++;
                $display("FAIL full_ready got ready=%b en=%b, expected 00 0", {wr_ready, rd_ready}, sram_en);
            end
            step();
        end
        wr_valid = 1'b0; rd_valid = 1'b0;
        sram_busy = 1'b0;
        drain(30);
        checks++;
        if (exp_iss.size() + exp_rsp.size() != 0 || {wr_ready, rd_ready} !== 2'b11) begin
            errors++;
            $display("FAIL full_drain got pending=%0d ready=%b, expected 0 11",
                     exp_iss.size() + exp_rsp.size(), {wr_ready, rd_ready});
        end
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_reset_mid_read();
        test_read_priority();
        test_back_to_back();
        test_starvation();
        test_busy_stall();
        test_full();
        step();
`ifdef SCPAD_BANK_PERF_EN
        checks++;
        if (perf_rd_cnt != 32'(n_rd) || perf_wr_cnt != 32'(n_wr) || perf_busy_cnt != 32'd8) begin
            errors++;
            $display("FAIL perf got rd=%0d wr=%0d busy=%0d, expected rd=%0d wr=%0d busy=8",
                     perf_rd_cnt, perf_wr_cnt, perf_busy_cnt, n_rd, n_wr);
        end
`endif
        checks++;
        if (n_rd != 22 || n_wr != 7) begin
            errors++;
            $display("FAIL issue_totals got rd=%0d wr=%0d, expected rd=22 wr=7", n_rd, n_wr);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
